// File: rtl/dsp_nco_sweep_if.sv
// dsp_nco_sweep_if: control, config and NCO-drive bundle of the sweep block.
// master drives config/commands, slave (the sweeper) drives NCO/status.
interface dsp_nco_sweep_if #(
  parameter int PHI_WIDTH   = 32,
  parameter int DWELL_WIDTH = 16
);
  logic                   start;
  logic                   abort;
  logic [PHI_WIDTH-1:0]   cfg_start;
  logic [PHI_WIDTH-1:0]   cfg_stop;
  logic [PHI_WIDTH-1:0]   cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [1:0]             cfg_mode;
  logic                   nco_en;
  logic [PHI_WIDTH-1:0]   phi_inc;
  logic                   busy;
  logic                   step_stb;
  logic                   sweep_wrap;
  logic                   done;

  modport master (
    output start,
    output abort,
    output cfg_start,
    output cfg_stop,
    output cfg_step,
    output cfg_dwell,
    output cfg_mode,
    input  nco_en,
    input  phi_inc,
    input  busy,
    input  step_stb,
    input  sweep_wrap,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    input  cfg_start,
    input  cfg_stop,
    input  cfg_step,
    input  cfg_dwell,
    input  cfg_mode,
    output nco_en,
    output phi_inc,
    output busy,
    output step_stb,
    output sweep_wrap,
    output done
  );
endinterface

// File: rtl/dsp_nco_sweep.sv
// dsp_nco_sweep: stepped linear chirp generator feeding NCO en/phi_inc.
// Define DSP_NCO_SWEEP_PAUSE_EN to add the hold (pause) input.
module dsp_nco_sweep #(
  parameter int PHI_WIDTH   = 32,
  parameter int DWELL_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DSP_NCO_SWEEP_PAUSE_EN
  input  logic hold,
`endif
  dsp_nco_sweep_if.slave bus
);

`ifndef DSP_NCO_SWEEP_PAUSE_EN
  logic hold;
  assign hold = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam logic [DWELL_WIDTH-1:0] D_ONE = 1;

  state_t                 state_q;
  logic [PHI_WIDTH-1:0]   start_q;
  logic [PHI_WIDTH-1:0]   stop_q;
  logic [PHI_WIDTH-1:0]   step_q;
  logic [DWELL_WIDTH-1:0] dlast_q;
  logic [DWELL_WIDTH-1:0] cnt_q;
  logic                   rep_q;
  logic                   tri_q;
  logic                   up_q;
  logic                   to_stop_q;
  logic [PHI_WIDTH-1:0]   phi_q;
  logic                   en_q;
  logic                   busy_q;
  logic                   stb_q;
  logic                   wrap_q;
  logic                   done_q;

  logic [PHI_WIDTH-1:0]   tgt;
  logic [PHI_WIDTH-1:0]   tgt_rev;
  logic [PHI_WIDTH-1:0]   nxt;
  logic [PHI_WIDTH-1:0]   nxt_rev;
  logic [DWELL_WIDTH-1:0] dwell_m1;
  logic                   at_end;
  logic                   do_adv;
  logic                   do_rep;
  logic                   do_tri;
  logic                   do_fin;

  // Saturating move toward tgt; 33-bit math so the top word never wraps.
  function automatic logic [PHI_WIDTH-1:0] step_to(
    input logic [PHI_WIDTH-1:0] cur,
    input logic [PHI_WIDTH-1:0] dst,
    input logic [PHI_WIDTH-1:0] stp,
    input logic                 up
  );
    logic [PHI_WIDTH:0] sum;
    logic [PHI_WIDTH:0] dif;
    sum     = {1'b0, cur} + {1'b0, stp};
    dif     = {1'b0, cur} - {1'b0, dst};
    step_to = dst;
    if (stp != '0) begin
      if (up) begin
        if (sum < {1'b0, dst})
          step_to = sum[PHI_WIDTH-1:0];
      end else if (dif > {1'b0, stp}) begin
        step_to = cur - stp;
      end
    end
  endfunction

  assign tgt      = to_stop_q ? stop_q : start_q;
  assign tgt_rev  = to_stop_q ? start_q : stop_q;
  assign nxt      = step_to(phi_q, tgt, step_q, up_q);
  assign nxt_rev  = step_to(phi_q, tgt_rev, step_q, !up_q);
  assign dwell_m1 = (bus.cfg_dwell == '0) ? '0
                  : bus.cfg_dwell - D_ONE;

  assign at_end = (phi_q == tgt);
  assign do_adv = !at_end;
  assign do_rep = at_end && rep_q;
  assign do_tri = at_end && tri_q;
  assign do_fin = at_end && !rep_q && !tri_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dlast_q   <= '0;
      cnt_q     <= '0;
      rep_q     <= 1'b0;
      tri_q     <= 1'b0;
      up_q      <= 1'b1;
      to_stop_q <= 1'b1;
      phi_q     <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      stb_q     <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      stb_q  <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q <= IDLE;
        phi_q   <= '0;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.start) begin
              start_q   <= bus.cfg_start;
              stop_q    <= bus.cfg_stop;
              step_q    <= bus.cfg_step;
              dlast_q   <= dwell_m1;
              cnt_q     <= dwell_m1;
              rep_q     <= (bus.cfg_mode == 2'b01);
              tri_q     <= (bus.cfg_mode == 2'b10);
              up_q      <= (bus.cfg_stop >= bus.cfg_start);
              to_stop_q <= 1'b1;
              phi_q     <= bus.cfg_start;
              en_q      <= 1'b1;
              busy_q    <= 1'b1;
              stb_q     <= 1'b1;
              state_q   <= RUN;
            end
          end
          RUN: begin
            if (!hold) begin
              if (cnt_q != '0) begin
                cnt_q <= cnt_q - D_ONE;
              end else begin
                cnt_q <= dlast_q;
                unique case (1'b1)
                  do_adv: begin
                    phi_q <= nxt;
                    stb_q <= 1'b1;
                  end
                  do_rep: begin
                    phi_q  <= start_q;
                    stb_q  <= 1'b1;
                    wrap_q <= 1'b1;
                  end
                  // endpoint already held; next word is one step back
                  do_tri: begin
                    phi_q     <= nxt_rev;
                    up_q      <= !up_q;
                    to_stop_q <= !to_stop_q;
                    stb_q     <= 1'b1;
                    wrap_q    <= 1'b1;
                  end
                  do_fin: begin
                    state_q <= FIN;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end
                  default: begin
                    state_q <= IDLE;
                  end
                endcase
              end
            end
          end
          FIN: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.nco_en     = en_q;
  assign bus.phi_inc    = phi_q;
  assign bus.busy       = busy_q;
  assign bus.step_stb   = stb_q;
  assign bus.sweep_wrap = wrap_q;
  assign bus.done       = done_q;

endmodule

// File: doc/dsp_nco_sweep.md
Name: dsp_nco_sweep

Overview:
- Frequency-sweep controller placed directly upstream of the NCO.
- Generates the NCO frequency control word (phi_inc) and enable (nco_en) as a stepped linear chirp from a start word to a stop word, holding each word for a programmable dwell.
- Supports single-shot, repeating sawtooth and continuous triangle sweeps.
- Output ports map one-to-one onto the NCO's en and phi_inc inputs.

Parameters:
- PHI_WIDTH, 32, width of frequency words; must equal the NCO's PHI_WIDTH.
- DWELL_WIDTH, 16, width of the dwell-cycle count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle sweep request; honoured only in IDLE
- abort  in  1  stop immediately, return to IDLE
- cfg_start  in  PHI_WIDTH  first frequency word (unsigned)
- cfg_stop  in  PHI_WIDTH  final frequency word (unsigned)
- cfg_step  in  PHI_WIDTH  step magnitude (unsigned); direction is derived
- cfg_dwell  in  DWELL_WIDTH  cycles each word is held; 0 is treated as 1
- cfg_mode  in  2  00 single, 01 repeat sawtooth, 10 triangle, 11 treated as 00
- nco_en  out  1  to NCO en
- phi_inc  out  PHI_WIDTH  to NCO phi_inc
- busy  out  1  high while sweeping
- step_stb  out  1  pulse on each cycle phi_inc takes a new value
- sweep_wrap  out  1  pulse when a repeat or triangle sweep reaches an endpoint and restarts or reverses
- done  out  1  single-cycle pulse at the end of a single sweep

Behaviour:
- Reset (async, rst_n=0): state IDLE; nco_en=0; phi_inc=0; busy, step_stb, sweep_wrap and done all 0; dwell counter 0.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1 and abort=0 at edge t:
  - All cfg_* inputs are latched.
  - dir=up if cfg_stop>=cfg_start, else down.
  - At t+1: phi_inc=cfg_start, nco_en=1, busy=1, step_stb=1, state RUN.
- cfg_* changes after start are ignored until the next start.
- RUN dwell counting:
  - D = max(cfg_dwell,1).
  - Every phi_inc value is held exactly D cycles, counted from the cycle it first appears.
- Next-word arithmetic (PHI_WIDTH+1 bits, no wrap-around):
  - Up: next = (cur+step >= target) ? target : cur+step.
  - Down: next = (cur-target <= step) ? target : cur-step.
  - step=0 is treated as an infinite step, so next = target.
- Endpoint reached: phi_inc==target and its D cycles have expired.
  - Single: FIN for one cycle. In that cycle nco_en=0, busy=0, done=1, and phi_inc holds the stop value. Then IDLE.
  - Repeat: next phi_inc=cfg_start, step_stb=1, sweep_wrap=1. Target stays cfg_stop.
  - Triangle: direction reverses, target swaps between cfg_stop and cfg_start, sweep_wrap=1. The first stepped value is emitted after the endpoint dwell; endpoints are held once, not twice.
- cfg_start==cfg_stop:
  - Single: one dwell of D cycles, then done.
  - Repeat/triangle: constant word with step_stb=1 and sweep_wrap=1 every D cycles.
- abort=1 in any state: next cycle is IDLE with nco_en=0, phi_inc=0, busy=0, no done. abort has priority over start in the same cycle.
- start while busy is ignored. start in the FIN cycle is ignored.
- step_stb, sweep_wrap and done are registered outputs, never combinational.

Optional Feature:
- Macro: DSP_NCO_SWEEP_PAUSE_EN.
- Defined:
  - Adds input port hold (1 bit).
  - While hold=1 in RUN, the dwell counter freezes, phi_inc is held, nco_en stays 1, and no strobes are emitted.
  - Counting resumes on the cycle after hold falls.
  - abort overrides hold.
- Undefined: no hold port; behaviour is identical to hold tied 0.

Test Plan:
- Single up: start=0x100, stop=0x400, step=0x100, dwell=3 -> phi_inc sequence 0x100,0x200,0x300,0x400, each held 3 cycles; done pulses on cycle 13 after start; nco_en low from that cycle.
- Clamp and down: start=0x500, stop=0x100, step=0x180, dwell=1 -> sequence 0x500,0x380,0x200,0x100, then done; no value below 0x100.
- Repeat: start=0x10, stop=0x30, step=0x10, dwell=2 -> 0x10,0x20,0x30,0x10,...; sweep_wrap pulses together with each return to 0x10; busy stays 1.
- Triangle: start=0, stop=0x20, step=0x10, dwell=1 -> 0,0x10,0x20,0x10,0,0x10; sweep_wrap pulses at 0x20→0x10 and 0→0x10.
- Boundaries:
  - dwell=0 behaves as dwell=1.
  - step=0 gives start then stop.
  - start=stop=0xFFFFFFFF with step=1 produces no overflow.
  - start pulsed mid-sweep is ignored.
- Abort/reset: abort on cycle 5 of a repeat sweep -> next cycle nco_en=0, phi_inc=0, no done; rst_n asserted mid-RUN clears all outputs asynchronously. With DSP_NCO_SWEEP_PAUSE_EN: hold for 4 cycles stretches that word's dwell by exactly 4 cycles.
